logic_unit_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer that shares one combinational logic unit among

---
 rtl/logic_unit_pkg.sv | 11 +
 rtl/logical.sv | 20 ++
 rtl/logic_unit_arbiter.sv | 130 +++++++++++++
 tb/tb_logic_unit_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared opcode encodings for the logic unit and its arbiter.
package logic_unit_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_AND = 2'b00;
    localparam op_t OP_OR  = 2'b01;
    localparam op_t OP_XOR = 2'b10;
    localparam op_t OP_NOT = 2'b11;

endpackage

// File: rtl/logical.sv
// Combinational logic unit: nibble-wise AND/OR/XOR of x=sendi[7:4], y=sendi[3:0], or byte NOT.
module logical
    import logic_unit_pkg::*;
(
    input  op_t        sel,
    input  logic [7:0] sendi,
    output logic [7:0] result_c
);

    always_comb begin
        result_c = 8'h00;
        case (sel)
            OP_AND:  result_c = {4'b0000, sendi[7:4] & sendi[3:0]};
            OP_OR:   result_c = {4'b0000, sendi[7:4] | sendi[3:0]};
            OP_XOR:  result_c = {4'b0000, sendi[7:4] ^ sendi[3:0]};
            default: result_c = ~sendi;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that time-shares one logic unit among NREQ requesters,
// returning a registered result tagged with the owning requester id.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] op,
    input  logic [8*NREQ-1:0] opnd,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_data,
    output logic [15:0]       ops_done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_next_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    op_t             r_op;
    logic [7:0]      r_opnd;
    logic [NREQ-1:0] r_gnt;
    logic            r_busy;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [7:0]      r_rsp_data;
    logic [15:0]     r_ops_done;

    logic            w_found;
    logic [IDW-1:0]  w_pick;
    op_t             w_sel_op;
    logic [7:0]      w_sel_opnd;
    logic [7:0]      w_result;
    int              w_dist;
    int              w_best_dist;

    // Pick the requester closest after r_ptr (distance 0 is r_ptr+1, modulo NREQ).
    always_comb begin
        w_found     = |req;
        w_pick      = '0;
        w_sel_op    = OP_AND;
        w_sel_opnd  = 8'h00;
        w_dist      = 0;
        w_best_dist = int'(NREQ);
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i + int'(NREQ) - 1 - int'(r_ptr)) % int'(NREQ);
            if (req[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_pick      = IDW'(i);
                w_sel_op    = op_t'(op[2*i +: 2]);
                w_sel_opnd  = opnd[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_found) w_next_state = ST_EXEC;
            ST_EXEC: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Capture on grant, publish the result one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= IDW'(NREQ - 1);
            r_id        <= '0;
            r_op        <= OP_AND;
            r_opnd      <= 8'h00;
            r_gnt       <= '0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= 8'h00;
            r_ops_done  <= 16'h0000;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_id   <= w_pick;
                        r_ptr  <= w_pick;
                        r_op   <= w_sel_op;
                        r_opnd <= w_sel_opnd;
                        r_gnt  <= NREQ'(1) << w_pick;
                        r_busy <= 1'b1;
                    end
                end
                default: begin
                    r_rsp_data  <= w_result;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_ops_done  <= r_ops_done + 16'd1;
                    r_gnt       <= '0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    logical u_logical (
        .sel      (r_op),
        .sendi    (r_opnd),
        .result_c (w_result)
    );

    assign gnt       = r_gnt;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: NREQ=4 main instance plus an NREQ=3 instance for wrap.
module tb_logic_unit_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  req4, gnt4;
    logic [7:0]  op4;
    logic [31:0] opnd4;
    logic        busy4, rv4;
    logic [1:0]  rid4;
    logic [7:0]  rd4;
    logic [15:0] od4;

    logic [2:0]  req3, gnt3;
    logic [5:0]  op3;
    logic [23:0] opnd3;
    logic        busy3, rv3;
    logic [1:0]  rid3;
    logic [7:0]  rd3;
    logic [15:0] od3;

    logic_unit_arbiter #(.NREQ(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req4), .op(op4), .opnd(opnd4), .gnt(gnt4), .busy(busy4),
        .rsp_valid(rv4), .rsp_id(rid4), .rsp_data(rd4), .ops_done(od4)
    );

    logic_unit_arbiter #(.NREQ(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3), .op(op3), .opnd(opnd3), .gnt(gnt3), .busy(busy3),
        .rsp_valid(rv3), .rsp_id(rid3), .rsp_data(rd3), .ops_done(od3)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    int         exp_g4[$];
    logic [9:0] exp_r4[$];
    int         exp_g3[$];
    logic [9:0] exp_r3[$];

    bit   chk_spacing = 1'b0;
    bit   prev_sp = 1'b0;
    int   last_g4 = -100;
    int   last_g3 = -100;
    int   m_ops4 = 0;
    int   e4, e3;
    logic [9:0] r4, r3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic set4(input int i, input logic [1:0] o, input logic [7:0] d);
        op4[2*i +: 2]   = o;
        opnd4[8*i +: 8] = d;
    endtask

    // Hold mask, drop each requester on its grant, optionally re-raise it one cycle later.
    task automatic drive4(input logic [3:0] mask, input int ngr, input bit rearm);
        int got = 0;
        int n = 0;
        logic [3:0] pend = '0;
        req4 = mask;
        while (got < ngr && n < 100) begin
            @(posedge clk); #1;
            n++;
            req4 = req4 | pend;
            pend = '0;
            if (gnt4 != '0) begin
                got++;
                req4 = req4 & ~gnt4;
                if (rearm) pend = gnt4;
            end
        end
        req4 = '0;
        chk("drive4_grants", 32'(got), 32'(ngr));
    endtask

    task automatic drive3(input logic [2:0] mask);
        int n = 0;
        req3 = mask;
        while (gnt3 == '0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        req3 = '0;
        chk("drive3_granted", 32'(gnt3 != '0), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Monitor for the NREQ=4 instance.
    always @(negedge clk) begin
        if (rst) begin
            m_ops4 = 0;
        end else begin
            if (gnt4 != '0) begin
                if (exp_g4.size() == 0) begin
                    n_total++; n_bad++;
                    $display("FAIL gnt4_unexpected: got %b want none", gnt4);
                end else begin
                    e4 = exp_g4.pop_front();
                    chk("gnt4", 32'(gnt4), 32'(4'b0001 << e4));
                end
                chk("busy4_with_gnt", 32'(busy4), 32'd1);
                if (chk_spacing && prev_sp) chk("gnt4_spacing", 32'(cyc - last_g4), 32'd2);
                prev_sp = chk_spacing;
                last_g4 = cyc;
            end
            if (rv4) begin
                if (exp_r4.size() == 0) begin
                    n_total++; n_bad++;
                    $display("FAIL rsp4_unexpected: got id=%0d data=%h want none", rid4, rd4);
                end else begin
                    r4 = exp_r4.pop_front();
                    chk("rsp4_id", 32'(rid4), 32'(r4[9:8]));
                    chk("rsp4_data", 32'(rd4), 32'(r4[7:0]));
                    chk("rsp4_ops_done", 32'(od4), 32'(m_ops4 + 1));
                    chk("rsp4_latency", 32'(cyc - last_g4), 32'd1);
                    m_ops4++;
                end
            end
        end
    end

    // Monitor for the NREQ=3 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt3 != '0) begin
                if (exp_g3.size() == 0) begin
                    n_total++; n_bad++;
                    $display("FAIL gnt3_unexpected: got %b want none", gnt3);
                end else begin
                    e3 = exp_g3.pop_front();
                    chk("gnt3", 32'(gnt3), 32'(3'b001 << e3));
                end
                last_g3 = cyc;
            end
            if (rv3) begin
                if (exp_r3.size() == 0) begin
                    n_total++; n_bad++;
                    $display("FAIL rsp3_unexpected: got id=%0d data=%h want none", rid3, rd3);
                end else begin
                    r3 = exp_r3.pop_front();
                    chk("rsp3_id", 32'(rid3), 32'(r3[9:8]));
                    chk("rsp3_data", 32'(rd3), 32'(r3[7:0]));
                    chk("rsp3_latency", 32'(cyc - last_g3), 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        req4 = '0; op4 = '0; opnd4 = '0;
        req3 = '0; op3 = '0; opnd3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt4), 32'd0);
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_rsp_valid", 32'(rv4), 32'd0);
        chk("rst_rsp_id", 32'(rid4), 32'd0);
        chk("rst_rsp_data", 32'(rd4), 32'd0);
        chk("rst_ops_done", 32'(od4), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single AND on requester 0.
        set4(0, 2'b00, 8'hF3);
        exp_g4.push_back(0); exp_r4.push_back({2'd0, 8'h03});
        drive4(4'b0001, 1, 1'b0);
        repeat (3) @(posedge clk); #1;

        // OR / XOR / NOT on requester 1.
        set4(1, 2'b01, 8'h12);
        exp_g4.push_back(1); exp_r4.push_back({2'd1, 8'h03});
        drive4(4'b0010, 1, 1'b0);
        repeat (3) @(posedge clk); #1;
        set4(1, 2'b10, 8'h6C);
        exp_g4.push_back(1); exp_r4.push_back({2'd1, 8'h0A});
        drive4(4'b0010, 1, 1'b0);
        repeat (3) @(posedge clk); #1;
        set4(1, 2'b11, 8'hA5);
        exp_g4.push_back(1); exp_r4.push_back({2'd1, 8'h5A});
        drive4(4'b0010, 1, 1'b0);
        repeat (3) @(posedge clk); #1;

        // Reset while a response is on the outputs: everything clears at once.
        set4(3, 2'b11, 8'h0F);
        exp_g4.push_back(3); exp_r4.push_back({2'd3, 8'hF0});
        drive4(4'b1000, 1, 1'b0);
        @(posedge clk);
        @(negedge clk); #1;
        chk("pre_rst_ops_done", 32'(od4), 32'd5);
        rst = 1'b1;
        #1;
        chk("async_rst_rsp_valid", 32'(rv4), 32'd0);
        chk("async_rst_rsp_data", 32'(rd4), 32'd0);
        chk("async_rst_ops_done", 32'(od4), 32'd0);
        chk("async_rst_busy", 32'(busy4), 32'd0);
        chk("async_rst_gnt", 32'(gnt4), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        // All four requesting, each re-raising one cycle after its drop.
        set4(0, 2'b00, 8'hF3);
        set4(1, 2'b01, 8'h12);
        set4(2, 2'b10, 8'h6C);
        set4(3, 2'b11, 8'hA5);
        for (int k = 0; k < 2; k++) begin
            exp_g4.push_back(0); exp_r4.push_back({2'd0, 8'h03});
            exp_g4.push_back(1); exp_r4.push_back({2'd1, 8'h03});
            exp_g4.push_back(2); exp_r4.push_back({2'd2, 8'h0A});
            exp_g4.push_back(3); exp_r4.push_back({2'd3, 8'h5A});
        end
        chk_spacing = 1'b1;
        drive4(4'b1111, 8, 1'b1);
        chk_spacing = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Reset during EXEC of requester 2: the operation is discarded.
        set4(2, 2'b10, 8'h35);
        req4 = 4'b0100;
        n = 0;
        while (gnt4 == '0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_gnt2", 32'(gnt4), 32'h4);
        req4 = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_gnt", 32'(gnt4), 32'd0);
        chk("t6_rst_busy", 32'(busy4), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        chk("t6_no_rsp", 32'(rv4), 32'd0);
        rst = 1'b0;
        chk("t6_ops_done", 32'(od4), 32'd0);
        set4(0, 2'b01, 8'h81);
        exp_g4.push_back(0); exp_r4.push_back({2'd0, 8'h09});
        exp_g4.push_back(2); exp_r4.push_back({2'd2, 8'h06});
        drive4(4'b0101, 2, 1'b0);
        repeat (3) @(posedge clk); #1;

        // NREQ=3 pointer wrap: 2, then 0 (wrap), then 2.
        op3   = {2'b10, 2'b00, 2'b00};
        opnd3 = {8'hFE, 8'h00, 8'h77};
        exp_g3.push_back(2); exp_r3.push_back({2'd2, 8'h01});
        drive3(3'b100);
        exp_g3.push_back(0); exp_r3.push_back({2'd0, 8'h07});
        drive3(3'b101);
        exp_g3.push_back(2); exp_r3.push_back({2'd2, 8'h01});
        drive3(3'b101);
        repeat (3) @(posedge clk); #1;

        chk("left_g4", 32'(exp_g4.size()), 32'd0);
        chk("left_r4", 32'(exp_r4.size()), 32'd0);
        chk("left_g3", 32'(exp_g3.size()), 32'd0);
        chk("left_r3", 32'(exp_r3.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
